// File: rtl/gray_pkg.sv
// Shared definitions for the Gray position decoder: tracker state encoding,
// the reference Gray-to-binary function and default synchronizer depth.
package gray_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int GRAY_MAX_W      = 32;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    // Decodes the low `width` bits of g; bits above width come back as zero.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] g,
        input int                    width
    );
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b & ({GRAY_MAX_W{1'b1}} >> (GRAY_MAX_W - width));
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational WIDTH-bit Gray-to-binary decoder, usable stand-alone
// against the binary-to-Gray encoder.
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic [GRAY_MAX_W-1:0] full;
    logic                  unused_hi;

    assign full      = gray2bin(GRAY_MAX_W'(gray), WIDTH);
    assign bin       = full[WIDTH-1:0];
    assign unused_hi = ^full;

endmodule

// File: rtl/gray_to_binary_tracker.sv
// Synchronizes and decodes an asynchronous Gray position, accepts only single
// steps, reports direction and counts wraps. Define GRAY_DEC_HYST_EN to add a
// one-cycle stability filter on the decoded value.
module gray_to_binary_tracker
    import gray_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int REV_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 valid,
    output logic                 step_up,
    output logic                 step_down,
    output logic                 err,
    output logic                 err_sticky,
    output logic [REV_WIDTH-1:0] rev_cnt
);

`ifdef GRAY_DEC_HYST_EN
    localparam int INIT_CNT = SYNC_STAGES + 2;
`else
    localparam int INIT_CNT = SYNC_STAGES + 1;
`endif
    localparam int CNT_W = $clog2(INIT_CNT + 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CNT);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL1      = '1;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  g_s;
    logic [WIDTH-1:0]                  g_bin;
    logic [WIDTH-1:0]                  d_bin;
    logic [WIDTH-1:0]                  diff;
    logic                              stable;
    logic [CNT_W-1:0]                  acq_cnt;
    state_e                            state;

    assign g_s = sync_q[SYNC_STAGES-1];

    gray_to_binary #(.WIDTH(WIDTH)) u_dec (
        .gray (g_s),
        .bin  (g_bin)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            d_bin  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};
            d_bin  <= g_bin;
        end
    end

`ifdef GRAY_DEC_HYST_EN
    // A decoded value must persist for two cycles before it is acted upon.
    logic [WIDTH-1:0] d_prev;
    always_ff @(posedge clk) begin
        if (!rst_n) d_prev <= '0;
        else        d_prev <= d_bin;
    end
    assign stable = (d_bin == d_prev);
`else
    assign stable = 1'b1;
`endif

    assign diff = d_bin - bin_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            acq_cnt    <= '0;
            bin_out    <= '0;
            valid      <= 1'b0;
            step_up    <= 1'b0;
            step_down  <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            rev_cnt    <= '0;
        end else begin
            step_up   <= 1'b0;
            step_down <= 1'b0;
            err       <= 1'b0;
            case (state)
                ST_INIT: begin
                    // Wait until the pipeline holds only samples taken after entry.
                    if (acq_cnt == INIT_LAST) begin
                        bin_out <= d_bin;
                        valid   <= 1'b1;
                        state   <= ST_TRACK;
                    end else begin
                        acq_cnt <= acq_cnt + 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (stable) begin
                        if (diff == ONE) begin
                            bin_out <= d_bin;
                            step_up <= 1'b1;
                            if (bin_out == ALL1) rev_cnt <= rev_cnt + 1'b1;
                        end else if (diff == ALL1) begin
                            bin_out   <= d_bin;
                            step_down <= 1'b1;
                            if (bin_out == '0) rev_cnt <= rev_cnt - 1'b1;
                        end else if (diff != '0) begin
                            err        <= 1'b1;
                            err_sticky <= 1'b1;
                            valid      <= 1'b0;
                            state      <= ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    if (clr_err) begin
                        err_sticky <= 1'b0;
                        acq_cnt    <= '0;
                        state      <= ST_INIT;
                    end
                end
                default: begin
                    valid   <= 1'b0;
                    acq_cnt <= '0;
                    state   <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Randomized bench for gray_to_binary_tracker (WIDTH=4, SYNC_STAGES=2, no filter)
// checked every cycle against an absolute-position reference model.
`timescale 1ns/1ps
module tb_gray_to_binary_tracker;

    logic       clk;
    logic       rst_n;
    logic [3:0] gray_in;
    logic       clr_err;
    logic [3:0] bin_out;
    logic       valid, step_up, step_down, err, err_sticky;
    logic [7:0] rev_cnt;

    int n_checks = 0;
    int n_errors = 0;

    gray_to_binary_tracker #(.WIDTH(4), .SYNC_STAGES(2), .REV_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .clr_err    (clr_err),
        .bin_out    (bin_out),
        .valid      (valid),
        .step_up    (step_up),
        .step_down  (step_down),
        .err        (err),
        .err_sticky (err_sticky),
        .rev_cnt    (rev_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: position tracked as a signed absolute count; bin is its low
    // nibble, revolutions are floor(abs/16) modulo 256.
    int m_abs, m_mode, m_wait;     // mode: 0 acquire, 1 track, 2 fault
    bit m_valid, m_up, m_dn, m_err, m_sticky;
    int dl[3];                     // decoded gray_in delayed by edges

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < 4; s++) b ^= (g >> s);
        return b & 15;
    endfunction

    task automatic model_edge();
        int d, delta;
        m_up = 0; m_dn = 0; m_err = 0;
        if (!rst_n) begin
            dl = '{0, 0, 0};
            m_abs = 0; m_valid = 0; m_sticky = 0; m_mode = 0; m_wait = 0;
            return;
        end
        d = dl[2];
        case (m_mode)
            0: if (m_wait == 3) begin
                   m_abs = ((m_abs >>> 4) <<< 4) + d;
                   m_valid = 1; m_mode = 1;
               end else m_wait++;
            1: begin
                   delta = (d - (m_abs & 15)) & 15;
                   if (delta == 1) begin m_abs++; m_up = 1; end
                   else if (delta == 15) begin m_abs--; m_dn = 1; end
                   else if (delta != 0) begin
                       m_err = 1; m_sticky = 1; m_valid = 0; m_mode = 2;
                   end
               end
            default: if (clr_err) begin m_sticky = 0; m_mode = 0; m_wait = 0; end
        endcase
        dl[2] = dl[1];
        dl[1] = dl[0];
        dl[0] = g2b(int'(gray_in));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("bin_out",    int'(bin_out),    m_abs & 15);
        chk("valid",      int'(valid),      int'(m_valid));
        chk("step_up",    int'(step_up),    int'(m_up));
        chk("step_down",  int'(step_down),  int'(m_dn));
        chk("err",        int'(err),        int'(m_err));
        chk("err_sticky", int'(err_sticky), int'(m_sticky));
        chk("rev_cnt",    int'(rev_cnt),    (m_abs >>> 4) & 255);
    endtask

    task automatic set_pos(input int p, input int hold);
        int q = p & 15;
        gray_in = 4'(q ^ (q >> 1));
        repeat (hold) tick();
    endtask

    int pos, act, hold;

    initial begin
        rst_n = 1'b0; clr_err = 1'b0; gray_in = '0; pos = 0;
        m_abs = 0; m_mode = 0; m_wait = 0; dl = '{0, 0, 0};
        tick(); tick();
        chk("rst_rev", int'(rev_cnt), 0);

        // Acquisition timing after reset release.
        rst_n = 1'b1;
        repeat (3) tick();
        chk("s1_valid_e3", int'(valid), 0);
        tick();
        chk("s1_valid_e4", int'(valid), 1);
        chk("s1_bin", int'(bin_out), 0);

        // Count up through the wrap, then back down across it.
        for (int p = 1; p <= 15; p++) set_pos(p, 5);
        set_pos(0, 6);
        chk("s3_rev", int'(rev_cnt), 1);
        set_pos(15, 6);
        chk("s4_rev", int'(rev_cnt), 0);
        chk("s4_bin", int'(bin_out), 15);
        set_pos(0, 6);

        // Illegal jump, then recovery via clr_err.
        set_pos(2, 6);
        chk("s5_sticky", int'(err_sticky), 1);
        chk("s5_valid", int'(valid), 0);
        chk("s5_bin", int'(bin_out), 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("s5_clr", int'(err_sticky), 0);
        repeat (3) tick();
        chk("s5_valid_e3", int'(valid), 0);
        tick();
        chk("s5_valid_e4", int'(valid), 1);
        chk("s5_bin2", int'(bin_out), 2);

        // Reset while faulted.
        set_pos(7, 6);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("s6_sticky", int'(err_sticky), 0);
        chk("s6_rev", int'(rev_cnt), 0);
        pos = 7;

        // Random walk with holds, illegal jumps, clears and resets.
        repeat (200) begin
            act  = $urandom_range(0, 99);
            hold = $urandom_range(1, 6);
            if (act < 40)      pos = pos + 1;
            else if (act < 72) pos = pos - 1;
            else if (act < 80) pos = pos + $urandom_range(2, 14);
            if (act >= 80 && act < 88) begin
                clr_err = 1'b1; tick(); clr_err = 1'b0;
            end else if (act >= 88 && act < 91) begin
                rst_n = 1'b0; tick(); rst_n = 1'b1;
            end
            set_pos(pos, hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gray_to_binary_tracker.md
Name: gray_to_binary_tracker

Overview:
- Decoder-side partner of the team's binary-to-Gray encoder.
- Samples an asynchronous Gray-coded position bus (rotary encoder or counter pointer crossing a clock domain), synchronizes it and decodes it to binary.
- Validates that every accepted change is a single Gray step; reports direction and counts revolutions on wrap-around.
- Sits between the pad/CDC boundary and position-consuming logic.

Parameters:
- WIDTH, 4, width of the Gray and binary position buses (min 2).
- SYNC_STAGES, 2, synchronizer flop stages on gray_in (min 2).
- REV_WIDTH, 8, width of the revolution counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- gray_in  input  WIDTH  asynchronous Gray-coded position.
- clr_err  input  1  level; leaves FAULT and restarts acquisition.
- bin_out  output  WIDTH  last accepted binary position.
- valid  output  1  high while bin_out is trustworthy (TRACK state).
- step_up  output  1  one-cycle pulse, accepted +1 step.
- step_down  output  1  one-cycle pulse, accepted -1 step.
- err  output  1  one-cycle pulse on an illegal jump.
- err_sticky  output  1  set with err; cleared only by clr_err in FAULT, or by reset.
- rev_cnt  output  REV_WIDTH  revolution count, modulo 2^REV_WIDTH.

Behaviour:
- Reset (rst_n low at an edge) clears all of the following; state is INIT with the acquisition counter at 0.
  - Outputs: bin_out, valid, step_up, step_down, err, err_sticky and rev_cnt are all 0.
  - Internal: the synchronizer flops and the decode register are also 0.
- Pipeline:
  - gray_in passes through SYNC_STAGES flops to g_s.
  - Decode register d_bin <= gray2bin(g_s), where b[W-1]=g[W-1] and b[i]=b[i+1]^g[i].
- Latency: a stable gray_in change reaches bin_out in SYNC_STAGES+2 edges.
- INIT:
  - The counter counts SYNC_STAGES+1 edges, so the pipeline holds only post-entry samples.
  - On the next edge: bin_out<=d_bin, valid<=1, go to TRACK. No step pulses are emitted.
- TRACK: diff = (d_bin - bin_out) mod 2^WIDTH.
  - diff==0: hold; no pulses.
  - diff==1: bin_out<=d_bin, step_up=1. If bin_out was all-ones (wrap to 0), rev_cnt+1, wrapping modulo 2^REV_WIDTH.
  - diff==2^WIDTH-1: bin_out<=d_bin, step_down=1. If bin_out was 0 (wrap to max), rev_cnt-1, wrapping modulo 2^REV_WIDTH.
  - Any other diff: err=1, err_sticky<=1, valid<=0, go to FAULT. bin_out and rev_cnt hold.
- FAULT:
  - bin_out and rev_cnt frozen; valid=0; pulses 0.
  - When clr_err is sampled high: err_sticky<=0, go to INIT (counter restarts).
  - rev_cnt is not cleared by clr_err.
- clr_err outside FAULT: ignored.
- Pulses are exclusive: at most one of step_up, step_down or err per cycle.
- Reset asserted in any state overrides everything on that edge.

Optional Feature:
- GRAY_DEC_HYST_EN defined:
  - Adds a glitch filter: TRACK accepts d_bin only if it equals the d_bin of the previous cycle.
  - Latency becomes SYNC_STAGES+3 edges.
  - The INIT count becomes SYNC_STAGES+2.
- Undefined: no filter, with the latencies stated above.

Decomposition:
- Shared package gray_pkg:
  - state encoding constants ST_INIT=2'd0, ST_TRACK=2'd1, ST_FAULT=2'd2;
  - gray2bin function, parameterized by WIDTH;
  - default SYNC_STAGES constant.
- One natural sub-module: gray_to_binary, a purely combinational WIDTH-parameterized decoder instantiated before d_bin, so it can be tested stand-alone against the encoder.

Test Plan:
All scenarios use WIDTH=4, SYNC_STAGES=2, feature undefined.
1. Reset release, gray_in=0000 held -> valid rises on edge 4 after rst_n high; bin_out=0; no pulses.
2. gray_in 0000->0001->0011, each held 6 cycles -> step_up pulses, bin_out 1 then 2, each 4 edges after the gray_in change.
3. Wrap up: settle at gray 1001 (bin 14), then 1000 (bin 15), then 0000 -> step_up x2; rev_cnt 0->1 on the 15->0 step.
4. Wrap down: from bin 0, gray_in 0000->1000 -> step_down; bin_out=15; rev_cnt decrements (1->0, or 0->255 from reset).
5. Illegal jump: gray_in 0000->0011 (bin 0->2) -> err pulse; err_sticky=1; valid=0; bin_out holds 0. Pulse clr_err -> err_sticky=0 on the next edge, and valid returns 4 edges later with bin_out=2.
6. Reset mid-operation: in FAULT with rev_cnt=3, drive rst_n low for one edge -> every output is 0 on that edge; then INIT reacquisition as in scenario 1.
